// File: rtl/core_avl_arb.sv
// ============================================================================
// Module      : core_avl_arb
// Description : Arbiter that merges the core's instruction-fetch (m0) and data
//               (m1) Avalon-MM masters onto one memory-side master port.
//               Command phase uses round-robin arbitration. In-order read
//               responses are routed back through an ID FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_avl_arb #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_PEND = 4
) (
    input  logic                clk,
    input  logic                rest,
    // Instruction-fetch master
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byte_en,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_write_data,
    output logic                m0_wait_request,
    output logic [DATA_W-1:0]   m0_read_data,
    output logic                m0_read_data_valid,
    // Data master
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byte_en,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_write_data,
    output logic                m1_wait_request,
    output logic [DATA_W-1:0]   m1_read_data,
    output logic                m1_read_data_valid,
    // Memory-side master
    output logic [ADDR_W-1:0]   s_address,
    output logic [DATA_W/8-1:0] s_byte_en,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_write_data,
    input  logic                s_wait_request,
    input  logic [DATA_W-1:0]   s_read_data,
    input  logic                s_read_data_valid,
    output logic                err_unexp_rsp
);

    localparam int                c_PTR_W = $clog2(MAX_PEND);
    localparam int                c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(MAX_PEND);

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic                 lock_id_q, lock_id_d;
    logic                 last_grant_q, last_grant_d;
    logic [MAX_PEND-1:0]  id_mem_q;
    logic [c_PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [c_CNT_W-1:0]   count_q, count_d;
    logic                 err_q;

    logic w_req0, w_req1;
    logic w_gnt_valid, w_gnt_id;
    logic w_gnt_read, w_gnt_write;
    logic w_fifo_full, w_fifo_empty;
    logic w_accept, w_push, w_pop, w_head;

    assign w_req0 = m0_read | m0_write;
    assign w_req1 = m1_read | m1_write;

    // Grant selection: locked grant wins; otherwise round-robin on contention.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_id    = 1'b0;
        if (state_q == ST_LOCK) begin
            w_gnt_valid = 1'b1;
            w_gnt_id    = lock_id_q;
        end else if (w_req0 && w_req1) begin
            w_gnt_valid = 1'b1;
            w_gnt_id    = ~last_grant_q;
        end else if (w_req0) begin
            w_gnt_valid = 1'b1;
            w_gnt_id    = 1'b0;
        end else if (w_req1) begin
            w_gnt_valid = 1'b1;
            w_gnt_id    = 1'b1;
        end
    end

    // Read wins over a simultaneous (illegal) write.
    assign w_gnt_read  = w_gnt_id ? m1_read : m0_read;
    assign w_gnt_write = w_gnt_id ? (m1_write & ~m1_read) : (m0_write & ~m0_read);

    assign w_fifo_full  = (count_q == c_FULL);
    assign w_fifo_empty = (count_q == '0);

    assign s_read       = w_gnt_valid & w_gnt_read & ~w_fifo_full;
    assign s_write      = w_gnt_valid & w_gnt_write;
    assign s_address    = (w_gnt_valid && w_gnt_id) ? m1_address    : m0_address;
    assign s_byte_en    = (w_gnt_valid && w_gnt_id) ? m1_byte_en    : m0_byte_en;
    assign s_write_data = (w_gnt_valid && w_gnt_id) ? m1_write_data : m0_write_data;

    assign w_accept        = (s_read | s_write) & ~s_wait_request;
    assign m0_wait_request = ~(w_accept & ~w_gnt_id);
    assign m1_wait_request = ~(w_accept &  w_gnt_id);

    // Full FIFO already blocks s_read, so push never collides with a full FIFO.
    assign w_push = w_accept & s_read;
    assign w_pop  = s_read_data_valid & ~w_fifo_empty;
    assign w_head = id_mem_q[rd_ptr_q];

    assign m0_read_data       = s_read_data;
    assign m1_read_data       = s_read_data;
    assign m0_read_data_valid = w_pop & ~w_head;
    assign m1_read_data_valid = w_pop &  w_head;
    assign err_unexp_rsp      = err_q;

    always_comb begin
        state_d      = ST_ARB;
        lock_id_d    = lock_id_q;
        last_grant_d = last_grant_q;
        count_d      = count_q;
        if ((s_read || s_write) && s_wait_request) begin
            state_d   = ST_LOCK;
            lock_id_d = w_gnt_id;
        end
        if (w_accept) begin
            last_grant_d = w_gnt_id;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            state_q      <= ST_ARB;
            lock_id_q    <= 1'b0;
            last_grant_q <= 1'b1;
            id_mem_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_id_q    <= lock_id_d;
            last_grant_q <= last_grant_d;
            count_q      <= count_d;
            if (w_push) begin
                id_mem_q[wr_ptr_q] <= w_gnt_id;
                wr_ptr_q           <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (s_read_data_valid && w_fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_core_avl_arb.sv
// ============================================================================
// Module      : tb_core_avl_arb
// Description : Directed self-checking bench for core_avl_arb.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_core_avl_arb;

    logic        clk;
    logic        rest;
    logic [31:0] m0_address, m1_address;
    logic [3:0]  m0_byte_en, m1_byte_en;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_write_data, m1_write_data;
    logic        m0_wait_request, m1_wait_request;
    logic [31:0] m0_read_data, m1_read_data;
    logic        m0_read_data_valid, m1_read_data_valid;
    logic [31:0] s_address;
    logic [3:0]  s_byte_en;
    logic        s_read, s_write;
    logic [31:0] s_write_data;
    logic        s_wait_request;
    logic [31:0] s_read_data;
    logic        s_read_data_valid;
    logic        err_unexp_rsp;

    int checks = 0;
    int errors = 0;

    core_avl_arb #(.ADDR_W(32), .DATA_W(32), .MAX_PEND(4)) dut (
        .clk                (clk),
        .rest               (rest),
        .m0_address         (m0_address),
        .m0_byte_en         (m0_byte_en),
        .m0_read            (m0_read),
        .m0_write           (m0_write),
        .m0_write_data      (m0_write_data),
        .m0_wait_request    (m0_wait_request),
        .m0_read_data       (m0_read_data),
        .m0_read_data_valid (m0_read_data_valid),
        .m1_address         (m1_address),
        .m1_byte_en         (m1_byte_en),
        .m1_read            (m1_read),
        .m1_write           (m1_write),
        .m1_write_data      (m1_write_data),
        .m1_wait_request    (m1_wait_request),
        .m1_read_data       (m1_read_data),
        .m1_read_data_valid (m1_read_data_valid),
        .s_address          (s_address),
        .s_byte_en          (s_byte_en),
        .s_read             (s_read),
        .s_write            (s_write),
        .s_write_data       (s_write_data),
        .s_wait_request     (s_wait_request),
        .s_read_data        (s_read_data),
        .s_read_data_valid  (s_read_data_valid),
        .err_unexp_rsp      (err_unexp_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then changed 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rest = 1'b1;
        m0_address = 32'h0; m1_address = 32'h0;
        m0_byte_en = 4'hF;  m1_byte_en = 4'hF;
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
        m0_write_data = 32'h0; m1_write_data = 32'h0;
        s_wait_request = 0; s_read_data = 32'h0; s_read_data_valid = 0;
        cyc(); cyc();
        rest = 1'b0;
        #1;
        check("rst_s_read",  s_read, 0);
        check("rst_s_write", s_write, 0);
        check("rst_m0_wait", m0_wait_request, 1);
        check("rst_m1_wait", m1_wait_request, 1);
        check("rst_m0_rdv",  m0_read_data_valid, 0);
        check("rst_err",     err_unexp_rsp, 0);

        // 1: simultaneous reads, m0 wins first contention
        cyc();
        m0_read = 1; m0_address = 32'h100;
        m1_read = 1; m1_address = 32'h200;
        #1;
        check("t1_c0_addr",   s_address, 32'h100);
        check("t1_c0_sread",  s_read, 1);
        check("t1_c0_m0wait", m0_wait_request, 0);
        check("t1_c0_m1wait", m1_wait_request, 1);
        cyc();
        m0_read = 0;
        #1;
        check("t1_c1_addr",   s_address, 32'h200);
        check("t1_c1_m1wait", m1_wait_request, 0);
        check("t1_c1_m0wait", m0_wait_request, 1);
        cyc();
        m1_read = 0;
        s_read_data_valid = 1; s_read_data = 32'hAAAA;
        #1;
        check("t1_r0_m0rdv",  m0_read_data_valid, 1);
        check("t1_r0_m1rdv",  m1_read_data_valid, 0);
        check("t1_r0_data",   m0_read_data, 32'hAAAA);
        cyc();
        s_read_data = 32'hBBBB;
        #1;
        check("t1_r1_m1rdv",  m1_read_data_valid, 1);
        check("t1_r1_m0rdv",  m0_read_data_valid, 0);
        check("t1_r1_data",   m1_read_data, 32'hBBBB);
        cyc();
        s_read_data_valid = 0;
        #1;
        check("t1_err", err_unexp_rsp, 0);

        // 2: stalled m1 write keeps its grant while m0 reads
        m1_write = 1; m1_address = 32'h300; m1_write_data = 32'h1234;
        s_wait_request = 1;
        #1;
        check("t2_s0_swrite", s_write, 1);
        check("t2_s0_addr",   s_address, 32'h300);
        check("t2_s0_m1wait", m1_wait_request, 1);
        cyc();
        m0_read = 1; m0_address = 32'h104;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("t2_lk_swrite", s_write, 1);
            check("t2_lk_sread",  s_read, 0);
            check("t2_lk_addr",   s_address, 32'h300);
            check("t2_lk_m0wait", m0_wait_request, 1);
            check("t2_lk_m1wait", m1_wait_request, 1);
            cyc();
        end
        s_wait_request = 0;
        #1;
        check("t2_acc_swrite", s_write, 1);
        check("t2_acc_addr",   s_address, 32'h300);
        check("t2_acc_wdata",  s_write_data, 32'h1234);
        check("t2_acc_m1wait", m1_wait_request, 0);
        check("t2_acc_m0wait", m0_wait_request, 1);
        cyc();
        m1_write = 0;
        #1;
        check("t2_m0_sread",  s_read, 1);
        check("t2_m0_addr",   s_address, 32'h104);
        check("t2_m0_wait",   m0_wait_request, 0);
        cyc();
        m0_read = 0;
        s_read_data_valid = 1; s_read_data = 32'h5555;
        #1;
        check("t2_rsp_m0rdv", m0_read_data_valid, 1);
        cyc();
        s_read_data_valid = 0;

        // 3: continuous writes from both alternate; m0 won last, so m1 first
        m0_write = 1; m0_address = 32'h400;
        m1_write = 1; m1_address = 32'h500;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t3_m1wait", m1_wait_request, (i % 2 == 0) ? 1'b0 : 1'b1);
            check("t3_m0wait", m0_wait_request, (i % 2 == 0) ? 1'b1 : 1'b0);
            check("t3_addr",   s_address, (i % 2 == 0) ? 32'h500 : 32'h400);
            cyc();
        end
        m0_write = 0; m1_write = 0;

        // 4: fill the response FIFO with m0 reads
        m0_read = 1; m0_address = 32'h600;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t4_fill_sread",  s_read, 1);
            check("t4_fill_m0wait", m0_wait_request, 0);
            cyc();
        end
        #1;
        check("t4_blk_m0wait", m0_wait_request, 1);
        check("t4_blk_sread",  s_read, 0);
        check("t4_blk_swrite", s_write, 0);
        cyc();
        m1_write = 1; m1_address = 32'h700;
        #1;
        check("t4_wr_swrite", s_write, 1);
        check("t4_wr_m1wait", m1_wait_request, 0);
        check("t4_wr_addr",   s_address, 32'h700);
        check("t4_wr_m0wait", m0_wait_request, 1);
        cyc();
        m1_write = 0;
        s_read_data_valid = 1; s_read_data = 32'h6000;
        #1;
        check("t4_pop_m0rdv",  m0_read_data_valid, 1);
        check("t4_pop_m0wait", m0_wait_request, 1);
        check("t4_pop_sread",  s_read, 0);
        cyc();
        s_read_data_valid = 0;
        #1;
        check("t4_5th_sread",  s_read, 1);
        check("t4_5th_m0wait", m0_wait_request, 0);
        cyc();
        m0_read = 0;
        s_read_data_valid = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t4_drain_m0rdv", m0_read_data_valid, 1);
            check("t4_drain_m1rdv", m1_read_data_valid, 0);
            cyc();
        end
        s_read_data_valid = 0;
        #1;
        check("t4_err", err_unexp_rsp, 0);

        // 5: unexpected response
        s_read_data_valid = 1;
        #1;
        check("t5_m0rdv", m0_read_data_valid, 0);
        check("t5_m1rdv", m1_read_data_valid, 0);
        cyc();
        s_read_data_valid = 0;
        #1;
        check("t5_err_set", err_unexp_rsp, 1);
        cyc();
        check("t5_err_held", err_unexp_rsp, 1);
        rest = 1;
        cyc();
        rest = 0;
        #1;
        check("t5_err_clr", err_unexp_rsp, 0);

        // 6: reset with two reads pending
        m1_read = 1; m1_address = 32'h800;
        cyc(); cyc();
        m1_read = 0;
        rest = 1;
        cyc();
        rest = 0;
        m0_read = 1; m0_address = 32'h900;
        #1;
        check("t6_sread",  s_read, 1);
        check("t6_m0wait", m0_wait_request, 0);
        cyc();
        m0_read = 0;
        s_read_data_valid = 1; s_read_data = 32'h9999;
        #1;
        check("t6_own_m0rdv", m0_read_data_valid, 1);
        cyc();
        #1;
        check("t6_stale_m1rdv", m1_read_data_valid, 0);
        check("t6_stale_m0rdv", m0_read_data_valid, 0);
        cyc();
        s_read_data_valid = 0;
        #1;
        check("t6_err", err_unexp_rsp, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/core_avl_arb.md
Name: core_avl_arb

Overview:
- Two-master to one-slave Avalon-MM arbiter that sits directly downstream of the core.
- Merges the core's instruction-fetch master port (m0) and data master port (m1) onto a single memory-side master port.
- Command phase uses round-robin arbitration. A grant stays locked while a command is stalled.
- Read responses return in order. An ID FIFO routes each response to the master that issued the read.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 32, data width on all ports.
- MAX_PEND, 4, depth of the response-routing FIFO, i.e. max outstanding reads (power of 2, ≥2).

Ports:
- clk  in  1  clock.
- rest  in  1  synchronous active-high reset.
- m0_address/m1_address  in  ADDR_W  upstream command address.
- m0_byte_en/m1_byte_en  in  DATA_W/8  byte enables.
- m0_read/m1_read  in  1  read request.
- m0_write/m1_write  in  1  write request.
- m0_write_data/m1_write_data  in  DATA_W  write data.
- m0_wait_request/m1_wait_request  out  1  command not accepted this cycle.
- m0_read_data/m1_read_data  out  DATA_W  read data (fanout of s_read_data).
- m0_read_data_valid/m1_read_data_valid  out  1  response valid for this port.
- s_address  out  ADDR_W  downstream address.
- s_byte_en  out  DATA_W/8  downstream byte enables.
- s_read  out  1  downstream read.
- s_write  out  1  downstream write.
- s_write_data  out  DATA_W  downstream write data.
- s_wait_request  in  1  downstream stall.
- s_read_data  in  DATA_W  downstream read data.
- s_read_data_valid  in  1  downstream response valid.
- err_unexp_rsp  out  1  sticky: response arrived with the FIFO empty.

Behaviour:
Port requests
- req_k = mk_read | mk_write.
- A master asserting both read and write is illegal; read takes precedence.

Arbitration states
- State ARB (unlocked):
  - If only one port requests, grant it.
  - If both request, grant the port ≠ last_grant.
  - last_grant resets to 1, so m0 wins the first contention.
- State LOCK:
  - Grant is held at lock_id regardless of the other port.
  - Entered when a granted command is presented downstream but not accepted that cycle (s_wait_request=1).
  - Exit to ARB in the cycle the command is accepted.
  - The grant does not switch mid-stall.

Command path (combinational mux from the granted port)
- Read block: read_blk = granted read & fifo_full.
- Downstream command:
  - s_read = granted read & ~read_blk.
  - s_write = granted write.
  - When nothing is granted, s_read=s_write=0 and the s_* data/address outputs hold the m0 values; they are don't-care.
- Acceptance: accept = (s_read|s_write) & ~s_wait_request.
- Wait request:
  - Granted port: wait_request = ~accept.
  - Ungranted port: wait_request = 1.
  - When idle, both wait_request = 1.
- On accept:
  - last_grant ← granted id.
  - If the command is a read, push the granted id into the FIFO.
- When read_blk=1, state stays ARB (no lock, no downstream command), so re-arbitration is allowed next cycle.

Response path
- On s_read_data_valid with FIFO non-empty:
  - Pop the head.
  - Assert mk_read_data_valid for k = head, in the same cycle (combinational).
- On s_read_data_valid with FIFO empty:
  - No upstream valid.
  - err_unexp_rsp ← 1, sticky until reset.

FIFO counting
- Push and pop in the same cycle: count unchanged.
- When full, push is blocked even if a pop occurs the same cycle. This keeps read_blk free of any s_read_data_valid dependency.
- Pointers wrap modulo MAX_PEND.
- count is clog2(MAX_PEND)+1 bits; never exceeds MAX_PEND.
- Writes never occupy the FIFO. A write may be accepted while the FIFO is full.

Reset
- rest=1 at a clock edge sets: state=ARB, last_grant=1, FIFO empty (count 0), err_unexp_rsp=0.
- Outputs after reset:
  - s_read=s_write=0 unless a port requests.
  - mk_read_data_valid=0.
  - mk_wait_request=1 while no request.
- Reset mid-transaction discards all pending response routes.
- Responses arriving after reset set err_unexp_rsp.

Latency
- Command path: 0 cycles (combinational).
- Response path: 0 cycles.
- State and FIFO updates take effect at the next clock edge.

Test Plan:
1. After reset, m0_read addr 0x100 and m1_read addr 0x200 asserted together, s_wait_request=0 → cycle0: s_address=0x100, m0 accepted, m1_wait_request=1; cycle1: s_address=0x200 accepted; responses 0xAAAA then 0xBBBB → m0_read_data_valid with 0xAAAA, then m1_read_data_valid with 0xBBBB.
2. m1_write 0x300 data 0x1234 with s_wait_request=1 for 3 cycles while m0_read is also asserted → s_write held with s_address=0x300 for 4 cycles, m0_wait_request=1 throughout; m0 is granted in the cycle after the write is accepted.
3. Alternating continuous requests from both ports → grants alternate m0,m1,m0,m1…, each port gets one accept every 2 cycles.
4. MAX_PEND=4, m0 issues 5 reads with no responses → 4 accepted, 5th sees m0_wait_request=1 and s_read=0; a concurrent m1_write is still accepted; after 1 response, the 5th read is accepted the next cycle.
5. s_read_data_valid pulse with no outstanding reads → no mk_read_data_valid, err_unexp_rsp=1 and held; rest=1 for 1 cycle → err_unexp_rsp=0.
6. 2 reads outstanding, rest pulsed → FIFO empty; the next read is accepted normally, and the stale response sets err_unexp_rsp.
